seg7_scan_driver: RTL and testbench

- Time-multiplexed scan driver for an 8-digit common-anode seven-segment display.
- Feeds the existing 4-bit hex-to-segment decoder: supplies its D3..D0 nibble, its LE (1 = display, 0 = blank) and its POINT (1 = point lit) inputs, and drives the digit anodes directly.
- Holds a tear-free, frame-synchronised copy of the displayed value and inserts blanking slots between digits to suppress ghosting.

---
 rtl/seg7_scan_driver.sv | 133 +++++++++++++
 tb/tb_seg7_scan_driver.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed scan driver for an 8-digit common-anode seven-segment display.
// Optional leading-zero suppression is enabled by defining SEG7_LEADING_ZERO_BLANK_EN.
module seg7_scan_driver #(
    parameter int CLK_DIV      = 4,
    parameter int BLANK_CYCLES = 1,
    parameter int NUM_DIGITS   = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] data_in,
    input  logic [7:0]  point_in,
    input  logic [7:0]  en_in,
    input  logic        load,
    output logic        pending,
    output logic [3:0]  digit_code,
    output logic        le,
    output logic        point,
    output logic [7:0]  an,
    output logic        frame_done
);

    localparam int             CW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0]  CNT_MAX = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0]  BLANK_C = CW'(BLANK_CYCLES);
    localparam logic [2:0]     DIG_MAX = 3'(NUM_DIGITS - 1);

    typedef struct packed {
        logic [7:0]  en;
        logic [7:0]  point;
        logic [31:0] data;
    } dispVal_t;

    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    dig_q, dig_d;
    dispVal_t      shadow_q, shadow_d;
    dispVal_t      active_q, active_d;
    logic          pending_q, pending_d;

    dispVal_t      inVal;
    logic          frameDone;
    logic          inBlank;
    logic          digitOn;
    logic [7:0]    suppress;

    assign inVal     = '{en: en_in, point: point_in, data: data_in};
    assign frameDone = (dig_q == DIG_MAX) && (cnt_q == CNT_MAX);

    generate
        if (BLANK_CYCLES == 0) begin : gNoBlank
            assign inBlank = 1'b0;
        end else begin : gBlank
            assign inBlank = (cnt_q < BLANK_C);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '0;
            dig_q     <= '0;
            shadow_q  <= '0;
            active_q  <= '0;
            pending_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            dig_q     <= dig_d;
            shadow_q  <= shadow_d;
            active_q  <= active_d;
            pending_q <= pending_d;
        end
    end

    // active only ever changes on the frame_done cycle, so a frame is never torn.
    always_comb begin
        cnt_d     = cnt_q + CW'(1);
        dig_d     = dig_q;
        shadow_d  = shadow_q;
        active_d  = active_q;
        pending_d = pending_q;
        if (cnt_q == CNT_MAX) begin
            cnt_d = '0;
            dig_d = (dig_q == DIG_MAX) ? 3'd0 : dig_q + 3'd1;
        end
        if (load && frameDone) begin
            shadow_d  = inVal;
            active_d  = inVal;
            pending_d = 1'b0;
        end else if (load) begin
            shadow_d  = inVal;
            pending_d = 1'b1;
        end else if (frameDone && pending_q) begin
            active_d  = shadow_q;
            pending_d = 1'b0;
        end
    end

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    logic zeroAbove;

    // A digit is hidden while it and every higher digit are zero with no point lit.
    always_comb begin
        zeroAbove = 1'b1;
        suppress  = '0;
        for (int i = 7; i >= 1; i--) begin
            if (i < NUM_DIGITS) begin
                zeroAbove   = zeroAbove && (active_q.data[4*i +: 4] == 4'h0) && !active_q.point[i];
                suppress[i] = zeroAbove;
            end
        end
    end
`else
    assign suppress = '0;
`endif

    assign digitOn = active_q.en[dig_q] && !suppress[dig_q];

    always_comb begin
        an         = 8'hFF;
        le         = 1'b0;
        point      = 1'b0;
        digit_code = active_q.data[{dig_q, 2'b00} +: 4];
        if (!inBlank) begin
            point = active_q.point[dig_q];
            if (digitOn) begin
                an[dig_q] = 1'b0;
                le        = 1'b1;
            end
        end
    end

    assign pending    = pending_q;
    assign frame_done = frameDone;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver: an independent cycle model pushes expected outputs,
// which are popped and compared at each falling edge, plus a few fixed-value spot checks.
module tb_seg7_scan_driver;

    localparam int CLK_DIV      = 4;
    localparam int BLANK_CYCLES = 1;
    localparam int NUM_DIGITS   = 8;
    localparam int FRAME        = CLK_DIV * NUM_DIGITS;

    typedef struct packed {
        logic [7:0] en;
        logic [7:0] point;
        logic [31:0] data;
    } val_t;

    typedef struct {
        logic [7:0] an;
        logic       le;
        logic       point;
        logic [3:0] code;
        logic       fd;
        logic       pending;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] data_in;
    logic [7:0]  point_in;
    logic [7:0]  en_in;
    logic        load;
    logic        pending;
    logic [3:0]  digit_code;
    logic        le;
    logic        point;
    logic [7:0]  an;
    logic        frame_done;

    int   checkCount = 0;
    int   passCount  = 0;
    int   mT;
    val_t mShadow;
    val_t mActive;
    logic mPending;
    exp_t expQ[$];

    seg7_scan_driver #(
        .CLK_DIV(CLK_DIV),
        .BLANK_CYCLES(BLANK_CYCLES),
        .NUM_DIGITS(NUM_DIGITS)
    ) dut (
        .clk(clk),
        .rst(rst),
        .data_in(data_in),
        .point_in(point_in),
        .en_in(en_in),
        .load(load),
        .pending(pending),
        .digit_code(digit_code),
        .le(le),
        .point(point),
        .an(an),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCount++;
        if (obs === exp) passCount++;
        else $display("[TB] FAIL %s t=%0d observed=%h expected=%h", tag, mT, obs, exp);
    endtask

    // Expected outputs are derived from the absolute cycle count rather than from counters.
    function automatic exp_t modelOut();
        exp_t e;
        int   slot;
        int   dg;
        int   msd;
        logic hidden;
        slot = mT % CLK_DIV;
        dg   = (mT / CLK_DIV) % NUM_DIGITS;
        msd  = 0;
        hidden = 1'b0;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        for (int j = 0; j < NUM_DIGITS; j++)
            if ((((mActive.data >> (4 * j)) & 32'hF) != 0) || mActive.point[j]) msd = j;
        hidden = (dg > msd);
`endif
        e.code    = 4'((mActive.data >> (4 * dg)) & 32'hF);
        e.fd      = ((mT % FRAME) == FRAME - 1);
        e.pending = mPending;
        e.an      = 8'hFF;
        e.le      = 1'b0;
        e.point   = 1'b0;
        if (slot >= BLANK_CYCLES) begin
            e.point = mActive.point[dg];
            if (mActive.en[dg] && !hidden) begin
                e.an = ~(8'h01 << dg);
                e.le = 1'b1;
            end
        end
        return e;
    endfunction

    task automatic applyStimulus(input logic ld, input logic [31:0] d, input logic [7:0] p,
                                 input logic [7:0] e, input logic r);
        exp_t got;
        val_t v;
        logic fd;
        load = ld; data_in = d; point_in = p; en_in = e; rst = r;
        expQ.push_back(modelOut());
        @(negedge clk);
        got = expQ.pop_front();
        checkOutput("an", 32'(an), 32'(got.an));
        checkOutput("le", 32'(le), 32'(got.le));
        checkOutput("point", 32'(point), 32'(got.point));
        checkOutput("digit_code", 32'(digit_code), 32'(got.code));
        checkOutput("frame_done", 32'(frame_done), 32'(got.fd));
        checkOutput("pending", 32'(pending), 32'(got.pending));
        v  = '{en: e, point: p, data: d};
        fd = got.fd;
        if (r) begin
            mT = 0; mShadow = '0; mActive = '0; mPending = 1'b0;
        end else begin
            if (ld && fd) begin
                mActive = v; mShadow = v; mPending = 1'b0;
            end else if (ld) begin
                mShadow = v; mPending = 1'b1;
            end else if (fd && mPending) begin
                mActive = mShadow; mPending = 1'b0;
            end
            mT++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic runTo(input int target);
        while (mT < target) applyStimulus(1'b0, 32'h0, 8'h0, 8'h0, 1'b0);
    endtask

    initial begin
        rst = 1'b1; load = 1'b0; data_in = '0; point_in = '0; en_in = '0;
        mT = 0; mShadow = '0; mActive = '0; mPending = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;

        #2;
        checkOutput("rst_an", 32'(an), 32'hFF);
        checkOutput("rst_le", 32'(le), 32'h0);
        runTo(1);
        #2;
        checkOutput("en0_an", 32'(an), 32'hFF);
        checkOutput("en0_code", 32'(digit_code), 32'h0);
        runTo(5);
        #2;
        checkOutput("dig1_old_le", 32'(le), 32'h0);
        applyStimulus(1'b1, 32'h12345678, 8'h01, 8'hFF, 1'b0);
        #2;
        checkOutput("pend_set", 32'(pending), 32'h1);
        runTo(32);
        #2;
        checkOutput("pend_clr", 32'(pending), 32'h0);
        runTo(33);
        #2;
        checkOutput("f1_an0", 32'(an), 32'hFE);
        checkOutput("f1_code0", 32'(digit_code), 32'h8);
        checkOutput("f1_point0", 32'(point), 32'h1);
        runTo(61);
        #2;
        checkOutput("f1_an7", 32'(an), 32'h7F);
        checkOutput("f1_code7", 32'(digit_code), 32'h1);

        // Two loads inside one frame: only the last is ever shown.
        runTo(66);
        applyStimulus(1'b1, 32'hAAAAAAAA, 8'h00, 8'hFF, 1'b0);
        runTo(70);
        applyStimulus(1'b1, 32'h55555555, 8'h00, 8'hFF, 1'b0);
        runTo(101);
        #2;
        checkOutput("last_wins_code", 32'(digit_code), 32'h5);
        checkOutput("last_wins_an", 32'(an), 32'hFD);

        runTo(127);
        #2;
        checkOutput("fd_pulse", 32'(frame_done), 32'h1);
        applyStimulus(1'b1, 32'h0000000F, 8'h00, 8'hFF, 1'b0);
        #2;
        checkOutput("bypass_code", 32'(digit_code), 32'hF);
        checkOutput("bypass_pend", 32'(pending), 32'h0);
        runTo(130);
        applyStimulus(1'b1, 32'h87654321, 8'h00, 8'hFF, 1'b0);
        runTo(145);
        #2;
        checkOutput("pre_rst_pend", 32'(pending), 32'h1);
        applyStimulus(1'b0, 32'h0, 8'h0, 8'h0, 1'b1);
        #2;
        checkOutput("post_rst_an", 32'(an), 32'hFF);
        checkOutput("post_rst_le", 32'(le), 32'h0);
        checkOutput("post_rst_pend", 32'(pending), 32'h0);
        runTo(3);
        applyStimulus(1'b1, 32'h00000305, 8'h00, 8'hFF, 1'b0);
        runTo(33);
        #2;
        checkOutput("lz_code0", 32'(digit_code), 32'h5);
        runTo(37);
        #2;
        checkOutput("lz_le1", 32'(le), 32'h1);
        checkOutput("lz_code1", 32'(digit_code), 32'h0);
        runTo(41);
        #2;
        checkOutput("lz_code2", 32'(digit_code), 32'h3);
        runTo(45);
        #2;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        checkOutput("lz_an3", 32'(an), 32'hFF);
        checkOutput("lz_le3", 32'(le), 32'h0);
`else
        checkOutput("lz_an3", 32'(an), 32'hF7);
        checkOutput("lz_le3", 32'(le), 32'h1);
`endif
        runTo(50);
        applyStimulus(1'b1, 32'h00000000, 8'h00, 8'hFF, 1'b0);
        runTo(65);
        #2;
        checkOutput("zero_an0", 32'(an), 32'hFE);
        runTo(69);
        #2;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        checkOutput("zero_an1", 32'(an), 32'hFF);
`else
        checkOutput("zero_an1", 32'(an), 32'hFD);
`endif
        runTo(100);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
